// File: rtl/game_event_gen.sv
// Game state machine and lane event source for the player life/money block.
// Define GAME_EVENT_PAUSE_EN to add a level 'pause' input that freezes play.
module game_event_gen #(
  parameter int unsigned TICK_DIV       = 25_000_000,
  parameter int unsigned WINDOW_TICKS   = 16,
  parameter int unsigned HITS_PER_LEVEL = 8,
  parameter logic [7:0]  LFSR_SEED      = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] btn,
  input  logic       fail,
`ifdef GAME_EVENT_PAUSE_EN
  input  logic       pause,
`endif
  output logic [3:0] state,
  output logic [3:0] target,
  output logic       hit,
  output logic       damage,
  output logic       ticket
);

  localparam int            PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [7:0]    WIN_L1     = 8'(WINDOW_TICKS);
  localparam logic [3:0]    HITS       = 4'(HITS_PER_LEVEL);
  localparam logic [7:0]    SEED       = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_L1   = 4'd1,
    S_L2   = 4'd2,
    S_L3   = 4'd3,
    S_L4   = 4'd4,
    S_FAIL = 4'd5
  } state_t;

  state_t        state_q, state_nxt;
  logic [7:0]    timer_q, timer_nxt;
  logic [3:0]    count_q, count_nxt;
  logic [PW-1:0] presc_q, presc_nxt;
  logic [7:0]    lfsr_q, lfsr_nxt;
  logic [3:0]    target_nxt;
  logic          hit_nxt, damage_nxt, ticket_nxt;

  logic play, frozen, tick, act;
  logic ev_hit, ev_bad, ev_tout, lvl_up, spawn;

  // Window shrinks by half per level but never below one tick.
  function automatic logic [7:0] sat_window(input logic [2:0] lvl);
    logic [7:0] w;
    w = WIN_L1 >> (lvl - 3'd1);
    return (w == 8'd0) ? 8'd1 : w;
  endfunction

  function automatic logic [1:0] pick_lane(input logic [1:0] rnd, input logic [1:0] cur);
    return (rnd == cur) ? rnd + 2'd1 : rnd;
  endfunction

  function automatic logic [1:0] lane_of(input logic [3:0] onehot);
    case (onehot)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  assign play = (state_q == S_L1) || (state_q == S_L2) ||
                (state_q == S_L3) || (state_q == S_L4);
`ifdef GAME_EVENT_PAUSE_EN
  assign frozen = play && pause;
`else
  assign frozen = 1'b0;
`endif
  assign tick    = play && !frozen && (presc_q == PRESC_LAST);
  assign act     = play && !fail && !frozen;
  assign ev_hit  = act && (btn == target);
  assign ev_bad  = act && (btn != 4'd0) && (btn != target);
  assign ev_tout = act && (btn == 4'd0) && tick && (timer_q == 8'd1);
  assign lvl_up  = ev_hit && ((count_q + 4'd1) == HITS);
  assign lfsr_nxt = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      target  <= 4'd0;
      hit     <= 1'b0;
      damage  <= 1'b0;
      ticket  <= 1'b0;
      timer_q <= 8'd0;
      count_q <= 4'd0;
      presc_q <= '0;
      lfsr_q  <= SEED;
    end else begin
      state_q <= state_nxt;
      target  <= target_nxt;
      hit     <= hit_nxt;
      damage  <= damage_nxt;
      ticket  <= ticket_nxt;
      timer_q <= timer_nxt;
      count_q <= count_nxt;
      presc_q <= presc_nxt;
      lfsr_q  <= lfsr_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_IDLE: if (start) state_nxt = S_L1;
      S_L1, S_L2, S_L3: begin
        if (fail)        state_nxt = S_FAIL;
        else if (lvl_up) state_nxt = state_t'(state_q + 4'd1);
      end
      S_L4:   if (fail)  state_nxt = S_FAIL;
      S_FAIL: if (start) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ticket_nxt = (state_q == S_IDLE) && start;
    hit_nxt    = ev_hit;
    damage_nxt = ev_bad || ev_tout;
    spawn      = ticket_nxt || ev_hit || ev_bad || ev_tout;
    target_nxt = 4'd0;
    timer_nxt  = timer_q;
    count_nxt  = count_q;
    presc_nxt  = '0;
    if (spawn) begin
      target_nxt = 4'b0001 << pick_lane(lfsr_q[1:0], lane_of(target));
      timer_nxt  = sat_window(state_nxt[2:0]);
    end else if (act) begin
      target_nxt = target;
      if (tick) timer_nxt = timer_q - 8'd1;
    end else if (play && !fail) begin
      target_nxt = target;
    end
    if (ticket_nxt)  count_nxt = 4'd0;
    else if (ev_hit) count_nxt = lvl_up ? 4'd0 : count_q + 4'd1;
    if (play) presc_nxt = frozen ? presc_q : ((presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1);
  end

  assign state = state_q;

endmodule

// File: tb/tb_game_event_gen.sv
// Directed bench for game_event_gen with a cycle-level behavioural model.
module tb_game_event_gen;
  localparam int TICK_DIV = 4;
  localparam int WIN      = 8;
  localparam int HITS     = 3;
`ifdef GAME_EVENT_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, start, fail, pause;
  logic [3:0] btn;
  logic [3:0] state, target;
  logic hit, damage, ticket;

  int n_checks = 0;
  int n_err    = 0;

  game_event_gen #(
    .TICK_DIV(TICK_DIV), .WINDOW_TICKS(WIN), .HITS_PER_LEVEL(HITS), .LFSR_SEED(8'hA5)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .btn(btn), .fail(fail),
`ifdef GAME_EVENT_PAUSE_EN
    .pause(pause),
`endif
    .state(state), .target(target), .hit(hit), .damage(damage), .ticket(ticket)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: game rules stated directly in integers.
  int         m_state, m_count, m_timer, m_pcyc;
  logic [3:0] m_target;
  logic [7:0] m_lfsr;
  bit         m_hit, m_dmg, m_ticket, m_play, m_frz, m_tick;

  task automatic m_spawn();
    int lane, cur, w;
    cur = 0;
    for (int i = 0; i < 4; i++) if (m_target[i]) cur = i;
    lane = m_lfsr % 4;
    if (lane == cur) lane = (lane + 1) % 4;
    m_target = 4'(1 << lane);
    w = WIN >> (m_state - 1);
    m_timer = (w < 1) ? 1 : w;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state = 0; m_target = 0; m_hit = 0; m_dmg = 0; m_ticket = 0;
      m_timer = 0; m_count = 0; m_pcyc = 0; m_lfsr = 8'hA5;
    end else begin
      m_play = (m_state >= 1) && (m_state <= 4);
      m_frz  = m_play && PAUSE_EN && pause;
      m_tick = m_play && !m_frz && ((m_pcyc % TICK_DIV) == TICK_DIV - 1);
      m_hit = 0; m_dmg = 0; m_ticket = 0;
      if (m_state == 0) begin
        if (start) begin m_ticket = 1; m_state = 1; m_count = 0; m_spawn(); end
      end else if (m_state == 5) begin
        if (start) m_state = 0;
      end else if (fail) begin
        m_state = 5; m_target = 0;
      end else if (!m_frz) begin
        if (btn == m_target) begin
          m_hit = 1; m_count++;
          if (m_count == HITS) begin m_count = 0; if (m_state < 4) m_state++; end
          m_spawn();
        end else if (btn != 0) begin
          m_dmg = 1; m_spawn();
        end else if (m_tick) begin
          if (m_timer == 1) begin m_dmg = 1; m_spawn(); end
          else m_timer--;
        end
      end
      m_pcyc = !m_play ? 0 : (m_frz ? m_pcyc : m_pcyc + 1);
      m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
    end
  end

  always @(negedge clk) begin
    check("state",  32'(state),  32'(m_state));
    check("target", 32'(target), 32'(m_target));
    check("hit",    32'(hit),    32'(m_hit));
    check("damage", 32'(damage), 32'(m_dmg));
    check("ticket", 32'(ticket), 32'(m_ticket));
  end

  task automatic wait_event(input int limit, output int cyc);
    cyc = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (hit || damage) begin cyc = i; break; end
    end
  endtask

  int cyc;
  logic [3:0] old_t;

  initial begin
    rst = 1'b1; start = 1'b0; fail = 1'b0; pause = 1'b0; btn = 4'd0;
    @(negedge clk);
    check("rst_state", 32'(state), 32'd0);
    check("rst_target", 32'(target), 32'd0);
    check("rst_pulses", 32'({hit, damage, ticket}), 32'd0);
    rst = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_ticket", 32'(ticket), 32'd1);
    check("start_state", 32'(state), 32'd1);
    check("start_target", 32'(target), 32'b0010);
    btn = m_target;
    @(negedge clk);
    check("hit1", 32'(hit), 32'd1);
    check("hit1_target", 32'(target), 32'b0100);
    btn = m_target;
    @(negedge clk);
    check("hit2_target", 32'(target), 32'b0010);
    check("hit2_state", 32'(state), 32'd1);
    btn = m_target;
    @(negedge clk);
    btn = 4'd0;
    check("hit3_state", 32'(state), 32'd2);
    check("hit3_target", 32'(target), 32'b0100);
    // Tick phase carries over from level 1, so the 4-tick window ends 13 clk later.
    wait_event(40, cyc);
    check("l2_timeout_cyc", 32'(cyc), 32'd13);
    check("l2_timeout_dmg", 32'(damage), 32'd1);

    btn = 4'b0011;
    @(negedge clk);
    btn = 4'd0;
    check("multi_dmg", 32'(damage), 32'd1);
    check("multi_hit", 32'(hit), 32'd0);
    @(negedge clk);
    btn = ((m_target << 1) | (m_target >> 3)) & 4'hF;
    @(negedge clk);
    btn = 4'd0;
    check("wrong_dmg", 32'(damage), 32'd1);
    check("wrong_hit", 32'(hit), 32'd0);
    for (int k = 1; k <= 3; k++) begin
      btn = m_target;
      @(negedge clk);
      btn = 4'd0;
      check("lvl_hit", 32'(hit), 32'd1);
      check("lvl_state", 32'(state), (k < 3) ? 32'd2 : 32'd3);
    end

    btn = m_target; fail = 1'b1;
    @(negedge clk);
    btn = 4'd0; fail = 1'b0;
    check("fail_state", 32'(state), 32'd5);
    check("fail_target", 32'(target), 32'd0);
    check("fail_hit", 32'(hit), 32'd0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("fail_exit_state", 32'(state), 32'd0);
    check("fail_exit_ticket", 32'(ticket), 32'd0);

    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("g2_ticket", 32'(ticket), 32'd1);
    old_t = target;
    wait_event(40, cyc);
    check("l1_timeout_cyc", 32'(cyc), 32'd32);
    check("l1_timeout_dmg", 32'(damage), 32'd1);
    check("l1_new_target", 32'(target != old_t && $onehot(target)), 32'd1);

`ifdef GAME_EVENT_PAUSE_EN
    cyc = -1;
    for (int i = 1; i <= 200; i++) begin
      pause = (i >= 5) && (i <= 104);
      btn   = pause ? m_target : 4'd0;
      @(negedge clk);
      if (hit || damage) begin cyc = i; break; end
    end
    pause = 1'b0; btn = 4'd0;
    check("pause_timeout_cyc", 32'(cyc), 32'd132);
    check("pause_timeout_dmg", 32'(damage), 32'd1);
`endif

    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_state", 32'(state), 32'd0);
    check("async_rst_target", 32'(target), 32'd0);
    check("async_rst_pulses", 32'({hit, damage, ticket}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
